aes_round_sequencer: RTL and testbench

- Parametrised AES round control FSM. Supports encrypt and decrypt, 10/12/14 rounds (AES-128/192/256) and a multi-cycle MixColumns.
- Drives the state-register datapath: load, op select, MixColumns column index, round-key select.
- Hands key expansion off to the key-schedule block through a start/done handshake. There is no fixed wait count.
- Sits between the AES top-level (start/done) and the AES datapath/key-schedule.

---
 rtl/aes_round_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
// Round-control FSM for an iterative AES core. It sequences the state-register
// datapath through the initial AddRoundKey, NUM_ROUNDS-1 full rounds and the
// final round (no MixColumns), for encryption or decryption. Key expansion is
// delegated to the key-schedule block through a start/done handshake.
//
// Ports
//   CLK, RESET      clock, synchronous active-high reset
//   AES_START       level request from the AES top; starts from IDLE, releases DONE
//   MODE            0 = encrypt, 1 = decrypt (captured when the run starts)
//   ABORT           cancels a run in progress
//   keyexp_done     key schedule finished (only honoured while waiting for it)
//   load_state      one-cycle strobe: datapath loads the input block
//   keyexp_start    one-cycle strobe to the key schedule
//   op_en / op      datapath operation for this cycle
//                   (0 SubBytes, 1 ShiftRows, 2 MixColumns, 3 AddRoundKey)
//   mix_col         column handled while op = MixColumns, 0 otherwise
//   round_idx       current round, 0..NUM_ROUNDS
//   key_sel         round-key index; updated on AddRoundKey cycles, held otherwise
//   busy            high in every state except IDLE and DONE
//   AES_DONE        result valid
// All outputs are flops loaded from the decode of the next state, so they
// line up exactly with the state register (Moore timing, glitch-free).
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int MC_CYCLES  = 4,
    parameter int RW         = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          AES_START,
    input  logic          MODE,
    input  logic          ABORT,
    input  logic          keyexp_done,
    output logic          load_state,
    output logic          keyexp_start,
    output logic          op_en,
    output logic [1:0]    op,
    output logic [1:0]    mix_col,
    output logic [RW-1:0] round_idx,
    output logic [RW-1:0] key_sel,
    output logic          busy,
    output logic          AES_DONE
);

    // Elaboration guards: unsupported configurations must not build.
    generate
        if (!((NUM_ROUNDS == 10) || (NUM_ROUNDS == 12) || (NUM_ROUNDS == 14))) begin : g_bad_num_rounds
            $error("aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
        end
        if ((MC_CYCLES < 1) || (MC_CYCLES > 4)) begin : g_bad_mc_cycles
            $error("aes_round_sequencer: MC_CYCLES must be in 1..4");
        end
        if (RW < $clog2(NUM_ROUNDS + 1)) begin : g_bad_rw
            $error("aes_round_sequencer: RW too narrow for NUM_ROUNDS");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_KEYEXP = 3'd2,
        ST_ARK0   = 3'd3,
        ST_RND    = 3'd4,
        ST_MIX    = 3'd5,
        ST_FINAL  = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    localparam logic [1:0]    OP_SUB   = 2'd0;
    localparam logic [1:0]    OP_SHIFT = 2'd1;
    localparam logic [1:0]    OP_MIX   = 2'd2;
    localparam logic [1:0]    OP_ARK   = 2'd3;
    localparam logic [RW-1:0] NR_W     = RW'(NUM_ROUNDS);
    localparam logic [RW-1:0] NR_LAST  = RW'(NUM_ROUNDS - 1);
    localparam logic [1:0]    MC_LAST  = 2'(MC_CYCLES - 1);

    // State and counters
    state_t        r_state;
    logic [RW-1:0] r_round;
    logic [1:0]    r_step;   // position inside a round outside the MixColumns burst
    logic [1:0]    r_col;    // MixColumns column
    logic          r_mode;

    // Registered outputs
    logic          r_load_state;
    logic          r_keyexp_start;
    logic          r_op_en;
    logic [1:0]    r_op;
    logic [1:0]    r_mix_col;
    logic [RW-1:0] r_key_sel;
    logic          r_busy;
    logic          r_done;

    // Next-state values
    state_t        w_fsm_state;
    state_t        w_state;
    logic [RW-1:0] w_round;
    logic [1:0]    w_step;
    logic [1:0]    w_col;
    logic          w_mode;
    logic          w_abort;
    logic          w_last_round;

    // Next-cycle output decode
    logic          w_load;
    logic          w_kstart;
    logic          w_op_en;
    logic [1:0]    w_op;
    logic [1:0]    w_mix_col;
    logic          w_key_upd;
    logic [RW-1:0] w_key_val;
    logic          w_busy;
    logic          w_done;

    assign w_last_round = (r_round == NR_LAST);
    assign w_abort      = ABORT && (r_state != ST_IDLE) && (r_state != ST_DONE);
    // ABORT overrides every other transition, including the final ARK -> DONE.
    assign w_state      = w_abort ? ST_IDLE : w_fsm_state;

    // Next-state and counter logic.
    always_comb begin
        w_fsm_state = r_state;
        w_round     = r_round;
        w_step      = r_step;
        w_col       = r_col;
        w_mode      = r_mode;
        case (r_state)
            ST_IDLE: begin
                if (AES_START) begin
                    w_mode      = MODE;
                    w_fsm_state = ST_LOAD;
                end else begin
                    w_fsm_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_fsm_state = ST_KEYEXP;
                w_round     = {RW{1'b0}};
                w_step      = 2'd0;
                w_col       = 2'd0;
            end
            ST_KEYEXP: begin
                if (keyexp_done) begin
                    w_fsm_state = ST_ARK0;
                end else begin
                    w_fsm_state = ST_KEYEXP;
                end
            end
            ST_ARK0: begin
                w_fsm_state = ST_RND;
                w_round     = {{(RW-1){1'b0}}, 1'b1};
                w_step      = 2'd0;
            end
            ST_RND: begin
                // Encrypt: step0 SUB, step1 SHIFT, MIX burst, step2 ARK.
                // Decrypt: step0 SHIFT, step1 SUB, step2 ARK, MIX burst.
                if (r_step == 2'd0) begin
                    w_step = 2'd1;
                end else if ((r_step == 2'd1) && !r_mode) begin
                    w_fsm_state = ST_MIX;
                    w_col       = 2'd0;
                end else if (r_step == 2'd1) begin
                    w_step = 2'd2;
                end else if (r_mode) begin
                    w_fsm_state = ST_MIX;
                    w_col       = 2'd0;
                end else if (w_last_round) begin
                    w_fsm_state = ST_FINAL;
                    w_round     = NR_W;
                    w_step      = 2'd0;
                end else begin
                    w_round = r_round + {{(RW-1){1'b0}}, 1'b1};
                    w_step  = 2'd0;
                end
            end
            ST_MIX: begin
                if (r_col != MC_LAST) begin
                    w_col = r_col + 2'd1;
                end else if (!r_mode) begin
                    // Encrypt returns for the round's AddRoundKey.
                    w_fsm_state = ST_RND;
                    w_step      = 2'd2;
                end else if (w_last_round) begin
                    w_fsm_state = ST_FINAL;
                    w_round     = NR_W;
                    w_step      = 2'd0;
                end else begin
                    w_fsm_state = ST_RND;
                    w_round     = r_round + {{(RW-1){1'b0}}, 1'b1};
                    w_step      = 2'd0;
                end
            end
            ST_FINAL: begin
                if (r_step == 2'd2) begin
                    w_fsm_state = ST_DONE;
                end else begin
                    w_step = r_step + 2'd1;
                end
            end
            ST_DONE: begin
                if (AES_START) begin
                    w_fsm_state = ST_DONE;
                end else begin
                    w_fsm_state = ST_IDLE;
                end
            end
            default: begin
                w_fsm_state = ST_IDLE;
            end
        endcase
    end

    // Output decode of the next state, loaded into the output flops.
    always_comb begin
        w_load    = 1'b0;
        w_kstart  = 1'b0;
        w_op_en   = 1'b0;
        w_op      = OP_SUB;
        w_mix_col = 2'd0;
        w_key_upd = 1'b0;
        w_key_val = {RW{1'b0}};
        w_busy    = 1'b1;
        w_done    = 1'b0;
        case (w_state)
            ST_IDLE: begin
                w_busy = 1'b0;
            end
            ST_LOAD: begin
                w_load   = 1'b1;
                w_kstart = 1'b1;
            end
            ST_KEYEXP: begin
                w_busy = 1'b1;
            end
            ST_ARK0: begin
                w_op_en   = 1'b1;
                w_op      = OP_ARK;
                w_key_upd = 1'b1;
                w_key_val = w_mode ? NR_W : {RW{1'b0}};
            end
            ST_RND, ST_FINAL: begin
                w_op_en = 1'b1;
                case (w_step)
                    2'd0: w_op = w_mode ? OP_SHIFT : OP_SUB;
                    2'd1: w_op = w_mode ? OP_SUB : OP_SHIFT;
                    default: begin
                        w_op      = OP_ARK;
                        w_key_upd = 1'b1;
                        if (w_state == ST_FINAL) begin
                            w_key_val = w_mode ? {RW{1'b0}} : NR_W;
                        end else begin
                            w_key_val = w_mode ? (NR_W - w_round) : w_round;
                        end
                    end
                endcase
            end
            ST_MIX: begin
                w_op_en   = 1'b1;
                w_op      = OP_MIX;
                w_mix_col = w_col;
            end
            ST_DONE: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= ST_IDLE;
            r_round        <= {RW{1'b0}};
            r_step         <= 2'd0;
            r_col          <= 2'd0;
            r_mode         <= 1'b0;
            r_load_state   <= 1'b0;
            r_keyexp_start <= 1'b0;
            r_op_en        <= 1'b0;
            r_op           <= 2'd0;
            r_mix_col      <= 2'd0;
            r_key_sel      <= {RW{1'b0}};
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_round        <= w_round;
            r_step         <= w_step;
            r_col          <= w_col;
            r_mode         <= w_mode;
            r_load_state   <= w_load;
            r_keyexp_start <= w_kstart;
            r_op_en        <= w_op_en;
            r_op           <= w_op;
            r_mix_col      <= w_mix_col;
            r_busy         <= w_busy;
            r_done         <= w_done;
            if (w_key_upd) begin
                r_key_sel <= w_key_val;
            end else begin
                r_key_sel <= r_key_sel;
            end
        end
    end

    assign load_state   = r_load_state;
    assign keyexp_start = r_keyexp_start;
    assign op_en        = r_op_en;
    assign op           = r_op;
    assign mix_col      = r_mix_col;
    assign round_idx    = r_round;
    assign key_sel      = r_key_sel;
    assign busy         = r_busy;
    assign AES_DONE     = r_done;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
// Directed bench for aes_round_sequencer. u_dut uses the default
// configuration (NR=10, MC=4); u_dut14 uses NR=14, MC=1. Outputs are sampled
// 1 time unit after the rising edge; inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;

    // Default-configuration DUT
    logic       a_start, a_mode, a_abort, a_kdone;
    logic       d_load, d_kstart, d_op_en, d_busy, d_done;
    logic [1:0] d_op, d_col;
    logic [3:0] d_round, d_key;

    // NR=14, MC=1 DUT
    logic       b_start, b_mode, b_abort, b_kdone;
    logic       e_load, e_kstart, e_op_en, e_busy, e_done;
    logic [1:0] e_op, e_col;
    logic [3:0] e_round, e_key;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected op stream for one u_dut run: {op, mix_col, key_sel, round_idx}
    logic [11:0] q_exp[$];

    always #5 CLK = ~CLK;

    aes_round_sequencer u_dut (
        .CLK(CLK), .RESET(RESET), .AES_START(a_start), .MODE(a_mode),
        .ABORT(a_abort), .keyexp_done(a_kdone), .load_state(d_load),
        .keyexp_start(d_kstart), .op_en(d_op_en), .op(d_op), .mix_col(d_col),
        .round_idx(d_round), .key_sel(d_key), .busy(d_busy), .AES_DONE(d_done)
    );

    aes_round_sequencer #(.NUM_ROUNDS(14), .MC_CYCLES(1), .RW(4)) u_dut14 (
        .CLK(CLK), .RESET(RESET), .AES_START(b_start), .MODE(b_mode),
        .ABORT(b_abort), .keyexp_done(b_kdone), .load_state(e_load),
        .keyexp_start(e_kstart), .op_en(e_op_en), .op(e_op), .mix_col(e_col),
        .round_idx(e_round), .key_sel(e_key), .busy(e_busy), .AES_DONE(e_done)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int o, input int c, input int k, input int r);
        q_exp.push_back({2'(o), 2'(c), 4'(k), 4'(r)});
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({d_load, d_kstart, d_op_en, d_op, d_col, d_round, d_key, d_busy, d_done} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_dut10 got=%h want=0", {d_load, d_kstart, d_op_en, d_op, d_col, d_round, d_key, d_busy, d_done});
        end
        n_checks++;
        if ({e_load, e_kstart, e_op_en, e_op, e_col, e_round, e_key, e_busy, e_done} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_dut14 got=%h want=0", {e_load, e_kstart, e_op_en, e_op, e_col, e_round, e_key, e_busy, e_done});
        end
        RESET = 1'b0;
        tick();
    endtask

    // Full NR=10/MC=4 run on u_dut, keyexp_done raised after k KEYEXP cycles.
    // Leaves AES_START high, so the DUT ends parked in DONE.
    task automatic test_run(input bit dec, input int k);
        int key;
        int opcnt;
        int idx;
        int exp_done;
        q_exp.delete();
        key = dec ? 10 : 0;
        push_exp(3, 0, key, 0);
        for (int r = 1; r <= 9; r++) begin
            if (!dec) begin
                push_exp(0, 0, key, r);
                push_exp(1, 0, key, r);
                for (int c = 0; c < 4; c++) push_exp(2, c, key, r);
                key = r;
                push_exp(3, 0, key, r);
            end else begin
                push_exp(1, 0, key, r);
                push_exp(0, 0, key, r);
                key = 10 - r;
                push_exp(3, 0, key, r);
                for (int c = 0; c < 4; c++) push_exp(2, c, key, r);
            end
        end
        push_exp(dec ? 1 : 0, 0, key, 10);
        push_exp(dec ? 0 : 1, 0, key, 10);
        key = dec ? 0 : 10;
        push_exp(3, 0, key, 10);

        exp_done = 2 + k + 1 + 9 * (3 + 4) + 3;
        opcnt    = 0;
        a_mode   = dec;
        a_start  = 1'b1;
        for (int cyc = 1; cyc <= exp_done; cyc++) begin
            tick();
            opcnt = opcnt + int'(d_op_en);
            if (cyc == 1) a_mode = !dec;   // must not affect the running operation
            a_kdone = (cyc == k + 1);
            idx = cyc - (k + 2);
            n_checks++;
            if (cyc == 1) begin
                if ({d_load, d_kstart, d_op_en, d_busy, d_done} !== 5'b11010) begin
                    n_fail++;
                    $display("FAIL load_pulse cyc=%0d got=%b want=11010", cyc, {d_load, d_kstart, d_op_en, d_busy, d_done});
                end
            end else if (cyc <= k + 1) begin
                if ({d_load, d_kstart, d_op_en, d_busy, d_done} !== 5'b00010) begin
                    n_fail++;
                    $display("FAIL keyexp_wait cyc=%0d got=%b want=00010", cyc, {d_load, d_kstart, d_op_en, d_busy, d_done});
                end
            end else if (idx < q_exp.size()) begin
                if ({d_load, d_kstart, d_op_en, d_busy, d_done, d_op, d_col, d_key, d_round} !==
                    {5'b00110, q_exp[idx]}) begin
                    n_fail++;
                    $display("FAIL op_seq dec=%0d cyc=%0d got=%b_%h want=00110_%h", dec, cyc,
                             {d_load, d_kstart, d_op_en, d_busy, d_done}, {d_op, d_col, d_key, d_round}, q_exp[idx]);
                end
            end else begin
                if ({d_load, d_kstart, d_op_en, d_busy, d_done, d_round} !== {5'b00001, 4'd10}) begin
                    n_fail++;
                    $display("FAIL done_latency dec=%0d cyc=%0d got=%b round=%0d want=00001 round=10", dec, cyc,
                             {d_load, d_kstart, d_op_en, d_busy, d_done}, d_round);
                end
            end
        end
        a_kdone = 1'b0;
        n_checks++;
        if (opcnt != 67) begin
            n_fail++;
            $display("FAIL op_en_count dec=%0d got=%0d want=67", dec, opcnt);
        end
    endtask

    // DONE holds while AES_START stays high (ABORT ignored), then a one-cycle
    // drop releases it and a decrypt run follows.
    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            a_abort = (i == 2);
            tick();
            n_checks++;
            if ({d_load, d_kstart, d_op_en, d_busy, d_done} !== 5'b00001) begin
                n_fail++;
                $display("FAIL done_hold i=%0d got=%b want=00001", i, {d_load, d_kstart, d_op_en, d_busy, d_done});
            end
        end
        a_abort = 1'b0;
        a_start = 1'b0;
        tick();
        n_checks++;
        if ({d_busy, d_done, d_load} !== 3'b000) begin
            n_fail++;
            $display("FAIL done_release got=%b want=000", {d_busy, d_done, d_load});
        end
        test_run(1'b1, 3);
        a_start = 1'b0;
        tick();
    endtask

    // ABORT in round 5, MixColumns column 2.
    task automatic test_abort();
        int  k;
        int  target;
        bit  saw;
        k       = 2;
        target  = k + 2 + 1 + 4 * 7 + 2 + 2;
        a_mode  = 1'b0;
        a_start = 1'b1;
        for (int cyc = 1; cyc <= target; cyc++) begin
            tick();
            a_start = 1'b0;
            a_kdone = (cyc == k + 1);
        end
        n_checks++;
        if ({d_op_en, d_op, d_col, d_round} !== {1'b1, 2'd2, 2'd2, 4'd5}) begin
            n_fail++;
            $display("FAIL abort_point got=%h want=%h", {d_op_en, d_op, d_col, d_round}, {1'b1, 2'd2, 2'd2, 4'd5});
        end
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        n_checks++;
        if ({d_op_en, d_busy, d_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_idle got=%b want=000", {d_op_en, d_busy, d_done});
        end
        saw = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            saw = saw | d_done | d_busy;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done got=%b want=0", saw);
        end
    endtask

    // RESET in KEYEXP together with keyexp_done; key_sel holds 4 from the aborted run.
    task automatic test_reset_keyexp();
        bit bad;
        a_mode  = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        n_checks++;
        if ({d_busy, d_key} !== {1'b1, 4'd4}) begin
            n_fail++;
            $display("FAIL pre_reset_keyexp got=%h want=%h", {d_busy, d_key}, {1'b1, 4'd4});
        end
        RESET   = 1'b1;
        a_kdone = 1'b1;
        tick();
        RESET   = 1'b0;
        a_kdone = 1'b0;
        n_checks++;
        if ({d_load, d_kstart, d_op_en, d_op, d_col, d_round, d_key, d_busy, d_done} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid got=%h want=0", {d_load, d_kstart, d_op_en, d_op, d_col, d_round, d_key, d_busy, d_done});
        end
        tick();
        a_kdone = 1'b1;
        tick();
        a_kdone = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            bad = bad | (|{d_load, d_kstart, d_op_en, d_op, d_col, d_round, d_key, d_busy, d_done});
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL kdone_idle got=%b want=0", bad);
        end
    endtask

    // NR=14, MC=1 encrypt with keyexp_done already high at KEYEXP entry.
    task automatic test_nr14();
        int  maxr;
        int  opcnt;
        bit  early;
        maxr    = 0;
        opcnt   = 0;
        early   = 1'b0;
        b_mode  = 1'b0;
        b_kdone = 1'b1;
        b_start = 1'b1;
        for (int cyc = 1; cyc <= 59; cyc++) begin
            tick();
            opcnt = opcnt + int'(e_op_en);
            if (int'(e_round) > maxr) maxr = int'(e_round);
            if (cyc < 59) early = early | e_done;
        end
        b_start = 1'b0;
        b_kdone = 1'b0;
        n_checks++;
        if ({early, e_done, e_busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL nr14_latency got early/done/busy=%b want=010", {early, e_done, e_busy});
        end
        n_checks++;
        if (maxr != 14) begin
            n_fail++;
            $display("FAIL nr14_round got=%0d want=14", maxr);
        end
        n_checks++;
        if (opcnt != 56) begin
            n_fail++;
            $display("FAIL nr14_op_en got=%0d want=56", opcnt);
        end
        n_checks++;
        if (e_key !== 4'd14) begin
            n_fail++;
            $display("FAIL nr14_final_key got=%0d want=14", e_key);
        end
        tick();
    endtask

    initial begin
        RESET   = 1'b1;
        a_start = 1'b0; a_mode = 1'b0; a_abort = 1'b0; a_kdone = 1'b0;
        b_start = 1'b0; b_mode = 1'b0; b_abort = 1'b0; b_kdone = 1'b0;
        test_reset();
        test_run(1'b0, 24);
        test_back_to_back();
        test_abort();
        test_reset_keyexp();
        test_nr14();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
